// File: rtl/audio_pkg.sv
// Shared audio definitions: note codes, melody entry layout, FSM states and
// the note-to-half-period conversion used by the sequencer.
package audio_pkg;

  localparam int unsigned HP_W = 17;

  typedef enum logic [2:0] {
    NOTE_A    = 3'd0,
    NOTE_B    = 3'd1,
    NOTE_CS   = 3'd2,
    NOTE_D    = 3'd3,
    NOTE_E    = 3'd4,
    NOTE_FS   = 3'd5,
    NOTE_GS   = 3'd6,
    NOTE_REST = 3'd7
  } note_code_t;

  typedef struct packed {
    note_code_t  code;
    logic [3:0]  dur;
  } seq_entry_t;

  localparam int unsigned ENTRY_W = $bits(seq_entry_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OFFER,
    ST_PLAY,
    ST_GAP
  } seq_state_t;

  // Integer note frequencies are chosen so that clkHz/(2*f) truncates to the
  // half-periods the tone generator expects at 50 MHz.
  function automatic logic [HP_W-1:0] hp_of(input note_code_t c, input int unsigned clkHz);
    int unsigned freq;
    case (c)
      NOTE_A:  freq = 440;
      NOTE_B:  freq = 493;
      NOTE_CS: freq = 554;
      NOTE_D:  freq = 587;
      NOTE_E:  freq = 659;
      NOTE_FS: freq = 740;
      NOTE_GS: freq = 830;
      default: freq = 0;
    endcase
    return (freq == 0) ? '0 : HP_W'(clkHz / (2 * freq));
  endfunction

  function automatic seq_entry_t mkEntry(input note_code_t c, input logic [3:0] d);
    return '{code: c, dur: d};
  endfunction

  localparam logic [16*ENTRY_W-1:0] DEFAULT_MELODY = {
    mkEntry(NOTE_A, 4'd4),    mkEntry(NOTE_E, 4'd1),
    mkEntry(NOTE_REST, 4'd1), mkEntry(NOTE_A, 4'd2),
    mkEntry(NOTE_B, 4'd1),    mkEntry(NOTE_CS, 4'd1),
    mkEntry(NOTE_D, 4'd1),    mkEntry(NOTE_E, 4'd2),
    mkEntry(NOTE_GS, 4'd1),   mkEntry(NOTE_FS, 4'd1),
    mkEntry(NOTE_REST, 4'd1), mkEntry(NOTE_E, 4'd2),
    mkEntry(NOTE_D, 4'd1),    mkEntry(NOTE_CS, 4'd1),
    mkEntry(NOTE_B, 4'd1),    mkEntry(NOTE_A, 4'd1)
  };

endpackage

// File: rtl/melody_rom.sv
// Melody table: SEQ_LEN entries of {code, dur}, synchronous read.
// Entry i lives in INIT[i*ENTRY_W +: ENTRY_W].
module melody_rom
  import audio_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 16,
  parameter int unsigned IDX_W   = 4,
  parameter logic [SEQ_LEN*ENTRY_W-1:0] INIT = DEFAULT_MELODY[SEQ_LEN*ENTRY_W-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] addr_i,
  output seq_entry_t       data_o
);

  seq_entry_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= INIT[int'(addr_i)*ENTRY_W +: ENTRY_W];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Walks the melody table, offers each note's half-period over valid/ready and
// times note, rest and articulation gap in clk cycles.
module melody_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 50_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int unsigned SEQ_LEN     = 16,
  parameter logic [SEQ_LEN*ENTRY_W-1:0] MELODY = DEFAULT_MELODY[SEQ_LEN*ENTRY_W-1:0],
  localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HP_W-1:0]  half_period,
  output logic             tone_en,
  output logic [IDX_W-1:0] note_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DUR_W = $clog2(15 * BEAT_CYCLES + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HP_W-1:0] HP_TAB [8] = '{
    hp_of(NOTE_A, CLOCK_FREQ),  hp_of(NOTE_B, CLOCK_FREQ),
    hp_of(NOTE_CS, CLOCK_FREQ), hp_of(NOTE_D, CLOCK_FREQ),
    hp_of(NOTE_E, CLOCK_FREQ),  hp_of(NOTE_FS, CLOCK_FREQ),
    hp_of(NOTE_GS, CLOCK_FREQ), hp_of(NOTE_REST, CLOCK_FREQ)
  };

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] noteIdx_q, noteIdx_d;
  logic [HP_W-1:0]  halfPeriod_q, halfPeriod_d;
  logic             outValid_q, outValid_d;
  logic             toneEn_q, toneEn_d;
  logic             done_q, done_d;
  logic             loadRdy_q, loadRdy_d;
  logic [DUR_W-1:0] durCnt_q, durCnt_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  seq_entry_t       romEntry;
  logic [3:0]       effDur;
  logic [DUR_W-1:0] durLoad;
  logic             lastIdx;
  logic             advance;

  // The ROM registers the entry at noteIdx_q, so LOAD spends its first cycle
  // letting the read settle and decodes the entry in its second cycle.
  melody_rom #(
    .SEQ_LEN (SEQ_LEN),
    .IDX_W   (IDX_W),
    .INIT    (MELODY)
  ) uRom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (noteIdx_q),
    .data_o (romEntry)
  );

  assign effDur  = (romEntry.dur == 4'd0) ? 4'd1 : romEntry.dur;
  assign durLoad = DUR_W'(32'(effDur) * BEAT_CYCLES - 32'd1);
  assign lastIdx = (noteIdx_q == IDX_W'(SEQ_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      noteIdx_q    <= '0;
      halfPeriod_q <= '0;
      outValid_q   <= 1'b0;
      toneEn_q     <= 1'b0;
      done_q       <= 1'b0;
      loadRdy_q    <= 1'b0;
      durCnt_q     <= '0;
      gapCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      noteIdx_q    <= noteIdx_d;
      halfPeriod_q <= halfPeriod_d;
      outValid_q   <= outValid_d;
      toneEn_q     <= toneEn_d;
      done_q       <= done_d;
      loadRdy_q    <= loadRdy_d;
      durCnt_q     <= durCnt_d;
      gapCnt_q     <= gapCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    noteIdx_d    = noteIdx_q;
    halfPeriod_d = halfPeriod_q;
    outValid_d   = outValid_q;
    toneEn_d     = toneEn_q;
    done_d       = 1'b0;
    loadRdy_d    = 1'b0;
    durCnt_d     = durCnt_q;
    gapCnt_d     = gapCnt_q;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          noteIdx_d = '0;
        end
      end
      ST_LOAD: begin
        if (!loadRdy_q) begin
          loadRdy_d = 1'b1;
        end else if (romEntry.code == NOTE_REST) begin
          state_d  = ST_PLAY;
          durCnt_d = durLoad;
          toneEn_d = 1'b0;
        end else begin
          state_d      = ST_OFFER;
          halfPeriod_d = HP_TAB[romEntry.code];
          outValid_d   = 1'b1;
        end
      end
      ST_OFFER: begin
        if (out_ready) begin
          state_d    = ST_PLAY;
          outValid_d = 1'b0;
          toneEn_d   = 1'b1;
          durCnt_d   = durLoad;
        end
      end
      ST_PLAY: begin
        if (durCnt_q == '0) begin
          toneEn_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d  = ST_GAP;
            gapCnt_d = GAP_W'(GAP_CYCLES - 1);
          end else begin
            advance = 1'b1;
          end
        end else begin
          durCnt_d = durCnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == '0) begin
          advance = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (!lastIdx) begin
        noteIdx_d = noteIdx_q + 1'b1;
        state_d   = ST_LOAD;
      end else if (loop_en) begin
        noteIdx_d = '0;
        state_d   = ST_LOAD;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    // Abort keeps note_idx and half_period so the last note stays observable.
    if (stop) begin
      state_d    = ST_IDLE;
      outValid_d = 1'b0;
      toneEn_d   = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_comb begin
    out_valid   = outValid_q;
    half_period = halfPeriod_q;
    tone_en     = toneEn_q;
    note_idx    = noteIdx_q;
    busy        = (state_q != ST_IDLE);
    done        = done_q;
  end

endmodule
